// File: rtl/hilo_transfer_unit.sv
// Sequencer between the Booth multiplier and the HI/LO registers: latches an operand
// pair, waits out the multiplier latency, then writes LO and HI over the shared bus.
module hilo_transfer_unit #(
    parameter int MUL_LATENCY = 1
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] ra_in,
    input  logic [31:0] rb_in,
    output logic [31:0] mul_ra,
    output logic [31:0] mul_rb,
    input  logic [63:0] mul_rz,
    input  logic        bus_grant,
    output logic [31:0] bus_out,
    output logic        lo_wr,
    output logic        hi_wr,
    output logic [31:0] lo_q,
    output logic [31:0] hi_q,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        WR_LO,
        WR_HI,
        DONE
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [63:0] prod_q, prod_d;
    logic [31:0] mulRa_q, mulRa_d;
    logic [31:0] mulRb_q, mulRb_d;
    logic [31:0] lo_d, hi_d;

    assign mul_ra = mulRa_q;
    assign mul_rb = mulRb_q;

    // Next-state and output decode; the operand latches deliberately hold after
    // completion so the multiplier inputs only move on an accepted start.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        prod_d  = prod_q;
        mulRa_d = mulRa_q;
        mulRb_d = mulRb_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        bus_out = '0;
        lo_wr   = 1'b0;
        hi_wr   = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    mulRa_d = ra_in;
                    mulRb_d = rb_in;
                    count_d = 4'(MUL_LATENCY);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (count_q != 4'd0) begin
                    count_d = count_q - 4'd1;
                end else begin
                    prod_d  = mul_rz;
                    state_d = WR_LO;
                end
            end
            WR_LO: begin
                bus_out = prod_q[31:0];
                lo_wr   = bus_grant;
                if (bus_grant) begin
                    lo_d    = prod_q[31:0];
                    state_d = WR_HI;
                end
            end
            WR_HI: begin
                bus_out = prod_q[63:32];
                hi_wr   = bus_grant;
                if (bus_grant) begin
                    hi_d    = prod_q[63:32];
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Clear wins over everything, including a pending write, so an abort leaves
    // HI/LO zeroed rather than half-updated.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= IDLE;
            count_q <= '0;
            prod_q  <= '0;
            mulRa_q <= '0;
            mulRb_q <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            prod_q  <= prod_d;
            mulRa_q <= mulRa_d;
            mulRb_q <= mulRb_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

endmodule
